sha256_msg_arbiter: RTL and testbench



---
 rtl/sha256_msg_arbiter_pkg.sv | 20 ++
 rtl/sha256_id_fifo.sv | 57 +++++
 rtl/sha256_msg_arbiter.sv | 133 +++++++++++++
 tb/tb_sha256_msg_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_arbiter_pkg.sv
// Shared types and interface widths for the SHA-256 message arbiter.
// The padder interface widths used by the arbiter are defined here.
package sha256_msg_arbiter_pkg;

    localparam int SHA_IF_DATA_W  = 64;
    localparam int SHA_IF_BYTES_W = 4;
    localparam int PERF_CNT_W     = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(
        input logic [PERF_CNT_W-1:0] v
    );
        return (&v) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sha256_id_fifo.sv
// Synchronous FIFO holding source IDs of granted messages, oldest first.
// Push is accepted when full only if a pop happens in the same cycle.
module sha256_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sha256_msg_arbiter.sv
// Round-robin, message-granular arbiter feeding one sha256_padder.
// Optional counters: define SHA256_MSG_ARBITER_PERF_CNT_EN.
module sha256_msg_arbiter
    import sha256_msg_arbiter_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int SRC_ID_W      = $clog2(NUM_SRC),
    parameter int ID_FIFO_DEPTH = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_SRC-1:0]                           src_arb_data_val,
    input  logic [NUM_SRC-1:0][SHA_IF_DATA_W-1:0]        src_arb_data,
    input  logic [NUM_SRC-1:0][SHA_IF_BYTES_W-1:0]       src_arb_data_padbytes,
    input  logic [NUM_SRC-1:0]                           src_arb_data_last,
    output logic [NUM_SRC-1:0]                           arb_src_rdy,
    output logic                                         arb_padder_data_val,
    output logic [SHA_IF_DATA_W-1:0]                     arb_padder_data,
    output logic [SHA_IF_BYTES_W-1:0]                    arb_padder_data_padbytes,
    output logic                                         arb_padder_data_last,
    input  logic                                         padder_arb_rdy,
    output logic                                         arb_dst_id_val,
    output logic [SRC_ID_W-1:0]                          arb_dst_id,
    input  logic                                         dst_arb_id_rdy
`ifdef SHA256_MSG_ARBITER_PERF_CNT_EN
    ,
    output logic [NUM_SRC-1:0][PERF_CNT_W-1:0]           arb_perf_msg_cnt,
    output logic [PERF_CNT_W-1:0]                        arb_perf_stall_cnt
`endif
);

    arb_state_e          state;
    logic [SRC_ID_W-1:0] grant_reg;
    logic [SRC_ID_W-1:0] rr_ptr;
    logic [SRC_ID_W-1:0] winner;
    logic [SRC_ID_W-1:0] idx;
    logic                found;
    logic                fifo_full;
    logic                fifo_empty;
    logic                can_push;
    logic                grant;
    logic                beat_acc;
    logic                msg_done;

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = SRC_ID_W'((int'(rr_ptr) + i) % NUM_SRC);
            if (!found && src_arb_data_val[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign arb_dst_id_val = !fifo_empty;
    assign can_push = !fifo_full || (arb_dst_id_val && dst_arb_id_rdy);
    assign grant    = (state == IDLE) && found && can_push;
    assign beat_acc = (state == LOCKED) && src_arb_data_val[grant_reg]
                      && padder_arb_rdy;
    assign msg_done = beat_acc && src_arb_data_last[grant_reg];

    always_comb begin
        arb_src_rdy              = '0;
        arb_padder_data_val      = 1'b0;
        arb_padder_data          = '0;
        arb_padder_data_padbytes = '0;
        arb_padder_data_last     = 1'b0;
        if (state == LOCKED) begin
            arb_src_rdy[grant_reg]   = padder_arb_rdy;
            arb_padder_data_val      = src_arb_data_val[grant_reg];
            arb_padder_data          = src_arb_data[grant_reg];
            arb_padder_data_padbytes = src_arb_data_padbytes[grant_reg];
            arb_padder_data_last     = src_arb_data_last[grant_reg];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_reg <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            state     <= LOCKED;
            grant_reg <= winner;
        end else if (msg_done) begin
            state  <= IDLE;
            rr_ptr <= (grant_reg == SRC_ID_W'(NUM_SRC - 1))
                      ? '0 : grant_reg + SRC_ID_W'(1);
        end
    end

    sha256_id_fifo #(
        .WIDTH (SRC_ID_W),
        .DEPTH (ID_FIFO_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (winner),
        .pop       (dst_arb_id_rdy),
        .rd_data   (arb_dst_id),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef SHA256_MSG_ARBITER_PERF_CNT_EN
    logic stall;

    // Only tag-FIFO back-pressure counts as a stall, not the normal bubble.
    assign stall = (state == IDLE) && (|src_arb_data_val) && !can_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_perf_msg_cnt   <= '0;
            arb_perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant && winner == SRC_ID_W'(i)) begin
                    arb_perf_msg_cnt[i] <= sat_inc(arb_perf_msg_cnt[i]);
                end
            end
            if (stall) begin
                arb_perf_stall_cnt <= sat_inc(arb_perf_stall_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sha256_msg_arbiter.sv
// Directed bench for sha256_msg_arbiter (4-source and 3-source builds).
module tb_sha256_msg_arbiter;
    import sha256_msg_arbiter_pkg::*;

    typedef logic [68:0] beat_t;

    logic clk;
    logic rst;

    logic [3:0]                     src_val;
    logic [3:0][SHA_IF_DATA_W-1:0]  src_data;
    logic [3:0][SHA_IF_BYTES_W-1:0] src_pb;
    logic [3:0]                     src_last;
    logic [3:0]                     src_rdy;
    logic                           pad_val;
    logic [SHA_IF_DATA_W-1:0]       pad_data;
    logic [SHA_IF_BYTES_W-1:0]      pad_pb;
    logic                           pad_last;
    logic                           pad_rdy;
    logic                           id_val;
    logic [1:0]                     id;
    logic                           id_rdy;

    logic [2:0]                     v3;
    logic [2:0][SHA_IF_DATA_W-1:0]  d3;
    logic [2:0][SHA_IF_BYTES_W-1:0] pb3;
    logic [2:0]                     l3;
    logic [2:0]                     r3;
    logic                           pv3;
    logic [SHA_IF_DATA_W-1:0]       pd3;
    logic [SHA_IF_BYTES_W-1:0]      ppb3;
    logic                           pl3;
    logic                           prdy3;
    logic                           idv3;
    logic [1:0]                     id3;
    logic                           idr3;

`ifdef SHA256_MSG_ARBITER_PERF_CNT_EN
    logic [3:0][PERF_CNT_W-1:0]     msg_cnt;
    logic [PERF_CNT_W-1:0]          stall_cnt;
    logic [2:0][PERF_CNT_W-1:0]     msg_cnt3;
    logic [PERF_CNT_W-1:0]          stall_cnt3;
`endif

    int          msgs_left [4];
    int          beat      [4];
    int          len       [4];
    int          mno       [4];
    logic [3:0]  pb        [4];
    logic [3:0]  rdy_s;
    logic [3:0]  val_s;
    beat_t       beat_log [$];
    int          id_log   [$];
    int          n_checks;
    int          n_errors;

    sha256_msg_arbiter #(
        .NUM_SRC       (4),
        .ID_FIFO_DEPTH (4)
    ) u_dut (
        .clk                      (clk),
        .rst                      (rst),
        .src_arb_data_val         (src_val),
        .src_arb_data             (src_data),
        .src_arb_data_padbytes    (src_pb),
        .src_arb_data_last        (src_last),
        .arb_src_rdy              (src_rdy),
        .arb_padder_data_val      (pad_val),
        .arb_padder_data          (pad_data),
        .arb_padder_data_padbytes (pad_pb),
        .arb_padder_data_last     (pad_last),
        .padder_arb_rdy           (pad_rdy),
        .arb_dst_id_val           (id_val),
        .arb_dst_id               (id),
        .dst_arb_id_rdy           (id_rdy)
`ifdef SHA256_MSG_ARBITER_PERF_CNT_EN
        ,
        .arb_perf_msg_cnt         (msg_cnt),
        .arb_perf_stall_cnt       (stall_cnt)
`endif
    );

    sha256_msg_arbiter #(
        .NUM_SRC       (3),
        .ID_FIFO_DEPTH (4)
    ) u_dut3 (
        .clk                      (clk),
        .rst                      (rst),
        .src_arb_data_val         (v3),
        .src_arb_data             (d3),
        .src_arb_data_padbytes    (pb3),
        .src_arb_data_last        (l3),
        .arb_src_rdy              (r3),
        .arb_padder_data_val      (pv3),
        .arb_padder_data          (pd3),
        .arb_padder_data_padbytes (ppb3),
        .arb_padder_data_last     (pl3),
        .padder_arb_rdy           (prdy3),
        .arb_dst_id_val           (idv3),
        .arb_dst_id               (id3),
        .dst_arb_id_rdy           (idr3)
`ifdef SHA256_MSG_ARBITER_PERF_CNT_EN
        ,
        .arb_perf_msg_cnt         (msg_cnt3),
        .arb_perf_stall_cnt       (stall_cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk_data(input int s, input int m,
                                            input int b);
        return {40'hA5_0000_0000, 8'(s), 8'(m), 8'(b)};
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src_val[i]  = (msgs_left[i] > 0);
            src_data[i] = mk_data(i, mno[i], beat[i]);
            src_last[i] = (beat[i] == len[i] - 1);
            src_pb[i]   = pb[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void clear_model();
        for (int i = 0; i < 4; i++) begin
            msgs_left[i] = 0;
            beat[i]      = 0;
            len[i]       = 1;
            mno[i]       = 0;
            pb[i]        = '0;
        end
    endfunction

    task automatic start_msg(input int s, input int n, input int l,
                             input int p);
        len[s]       = l;
        beat[s]      = 0;
        mno[s]       = 0;
        pb[s]        = 4'(p);
        msgs_left[s] = n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        beat_log.delete();
        id_log.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Source model and output monitor.
    initial begin
        forever begin
            @(negedge clk);
            rdy_s = src_rdy;
            val_s = src_val;
            if (pad_val && pad_rdy)
                beat_log.push_back({pad_last, pad_pb, pad_data});
            if (id_val && id_rdy)
                id_log.push_back(int'(id));
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int i = 0; i < 4; i++) begin
                    if (val_s[i] && rdy_s[i]) begin
                        if (beat[i] == len[i] - 1) begin
                            beat[i] = 0;
                            mno[i]++;
                            msgs_left[i]--;
                        end else begin
                            beat[i]++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        beat_t e;
        int    exp_src [4];
        int    exp_ids [5];
        int    k;

        n_checks = 0;
        n_errors = 0;
        pad_rdy  = 1'b1;
        id_rdy   = 1'b1;
        v3       = '0;
        l3       = 3'b111;
        pb3      = '0;
        prdy3    = 1'b1;
        idr3     = 1'b1;
        for (int i = 0; i < 3; i++) d3[i] = mk_data(i, 0, 0);
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_src_rdy", 64'(src_rdy), 64'h0);
        check("rst_pad_val", 64'(pad_val), 64'h0);
        check("rst_pad_last", 64'(pad_last), 64'h0);
        check("rst_pad_data", pad_data, 64'h0);
        check("rst_id_val", 64'(id_val), 64'h0);
        check("rst_id", 64'(id), 64'h0);

        // Single 3-beat message from source 2
        @(posedge clk);
        #2 start_msg(2, 1, 3, 5);
        @(negedge clk);
        check("t2_bubble", 64'(pad_val), 64'h0);
        repeat (10) @(posedge clk);
        #2;
        check("t2_nbeats", 64'(beat_log.size()), 64'd3);
        for (int b = 0; b < 3 && b < beat_log.size(); b++) begin
            e = beat_log[b];
            check("t2_data", e[63:0], mk_data(2, 0, b));
            check("t2_last", 64'(e[68]), 64'(b == 2));
        end
        if (beat_log.size() == 3) begin
            e = beat_log[2];
            check("t2_padbytes", 64'(e[67:64]), 64'd5);
        end
        check("t2_nids", 64'(id_log.size()), 64'd1);
        if (id_log.size() > 0) check("t2_id", 64'(id_log[0]), 64'd2);

        // Sources 0 and 3 compete with 2-beat messages
        do_reset();
        start_msg(0, 2, 2, 1);
        start_msg(3, 2, 2, 3);
        repeat (20) @(posedge clk);
        #2;
        exp_src = '{0, 3, 0, 3};
        check("t3_nbeats", 64'(beat_log.size()), 64'd8);
        for (int b = 0; b < 8 && b < beat_log.size(); b++) begin
            e = beat_log[b];
            check("t3_data", e[63:0],
                  mk_data(exp_src[b/2], b/4, b%2));
            check("t3_last", 64'(e[68]), 64'(b % 2 == 1));
        end
        check("t3_nids", 64'(id_log.size()), 64'd4);
        for (int m = 0; m < 4 && m < id_log.size(); m++)
            check("t3_id", 64'(id_log[m]), 64'(exp_src[m]));

        // Padder ready toggling during a 4-beat message from source 1
        do_reset();
        start_msg(1, 1, 4, 2);
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1 pad_rdy = ~pad_rdy;
            @(negedge clk);
            if (pad_val)
                check("t4_src_rdy", 64'(src_rdy),
                      64'(4'(pad_rdy) << 1));
        end
        pad_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("t4_nbeats", 64'(beat_log.size()), 64'd4);
        for (int b = 0; b < 4 && b < beat_log.size(); b++) begin
            e = beat_log[b];
            check("t4_data", e[63:0], mk_data(1, 0, b));
        end
        if (beat_log.size() == 4) begin
            e = beat_log[3];
            check("t4_last_pb", 64'(e[68:64]), 64'h12);
        end

        // Tag FIFO full: five 1-beat messages, consumer stalled
        do_reset();
        id_rdy = 1'b0;
        start_msg(0, 2, 1, 0);
        start_msg(1, 1, 1, 0);
        start_msg(2, 1, 1, 0);
        start_msg(3, 1, 1, 0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t5_nbeats_full", 64'(beat_log.size()), 64'd4);
        check("t5_id_val", 64'(id_val), 64'h1);
        check("t5_id_head", 64'(id), 64'h0);
        check("t5_stalled", 64'(pad_val), 64'h0);
`ifdef SHA256_MSG_ARBITER_PERF_CNT_EN
        check("t5_stall_cnt", 64'(stall_cnt != 0), 64'h1);
`endif
        @(posedge clk);
        #2 id_rdy = 1'b1;
        @(posedge clk);
        #2 id_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("t5_nbeats_pop", 64'(beat_log.size()), 64'd5);
        if (beat_log.size() == 5) begin
            e = beat_log[4];
            check("t5_fifth", e[63:0], mk_data(0, 1, 0));
        end
        id_rdy = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        exp_ids = '{0, 1, 2, 3, 0};
        check("t5_nids", 64'(id_log.size()), 64'd5);
        for (int m = 0; m < 5 && m < id_log.size(); m++)
            check("t5_id", 64'(id_log[m]), 64'(exp_ids[m]));
`ifdef SHA256_MSG_ARBITER_PERF_CNT_EN
        check("t5_msg_cnt0", 64'(msg_cnt[0]), 64'd2);
        check("t5_msg_cnt3", 64'(msg_cnt[3]), 64'd1);
`endif

        // Reset asserted mid-message
        do_reset();
        pad_rdy = 1'b0;
        id_rdy  = 1'b0;
        start_msg(1, 1, 4, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_locked", 64'(pad_val), 64'h1);
        check("t6_id_held", 64'(id_val), 64'h1);
        rst = 1'b1;
        clear_model();
        #1;
        check("t6_rst_pad_val", 64'(pad_val), 64'h0);
        check("t6_rst_id_val", 64'(id_val), 64'h0);
        check("t6_rst_src_rdy", 64'(src_rdy), 64'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        pad_rdy = 1'b1;
        id_rdy  = 1'b1;
        @(negedge clk);
        check("t6_after_id_val", 64'(id_val), 64'h0);
        check("t6_after_pad_val", 64'(pad_val), 64'h0);

        // Three sources: wrap of rr_ptr after source 2
        do_reset();
        @(posedge clk);
        #2 v3 = 3'b100;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!pv3 && k < 10);
        check("t7_grant2_val", 64'(pv3), 64'h1);
        check("t7_grant2_rdy", 64'(r3), 64'h4);
        check("t7_grant2_data", pd3, mk_data(2, 0, 0));
        @(posedge clk);
        #2 v3 = 3'b011;
        @(negedge clk);
        check("t7_bubble", 64'(pv3), 64'h0);
        @(negedge clk);
        check("t7_wrap_val", 64'(pv3), 64'h1);
        check("t7_wrap_rdy", 64'(r3), 64'h1);
        check("t7_wrap_data", pd3, mk_data(0, 0, 0));
        @(posedge clk);
        #2 v3 = 3'b000;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
